eeprom_burst_seq: RTL

Burst sequencer that sits directly upstream of `at24c02_ctl` and drives its parent-side byte handshake. It accepts a command (start address, length, read/write), streams write data in, and streams read data out. Write bursts are split into page-bounded segments, each staged in an internal page buffer before launch, because a ctl transaction cannot be stalled mid-byte. Read bursts are issued as one sequential-read transaction.

---
 rtl/eeprom_burst_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/eeprom_burst_seq.sv
// eeprom_burst_seq: burst sequencer in front of at24c02_ctl.
// Splits write bursts into page-bounded segments staged in a page buffer;
// issues read bursts as one sequential-read transaction.
// Ports:
//   clk, rst (async, active-low)
//   cmd_valid/cmd_ready/cmd_addr/cmd_len/cmd_wr : command handshake
//   wdata_valid/wdata_ready/wdata               : write-data stream
//   rdata_valid/rdata/rdata_last                : read-data stream
//   ctl_address/ctl_din/ctl_wr_en/ctl_parent_ready/ctl_last/ctl_dout/ctl_ready
//                                               : at24c02_ctl parent side
//   busy, done                                  : status
module eeprom_burst_seq #(
    parameter int ADDR_W     = 11,
    parameter int LEN_W      = 9,
    parameter int PAGE_BYTES = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_wr,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [7:0]        wdata,
    output logic              rdata_valid,
    output logic [7:0]        rdata,
    output logic              rdata_last,
    output logic [ADDR_W-1:0] ctl_address,
    output logic [7:0]        ctl_din,
    output logic              ctl_wr_en,
    output logic              ctl_parent_ready,
    output logic              ctl_last,
    input  logic [7:0]        ctl_dout,
    input  logic              ctl_ready,
    output logic              busy,
    output logic              done
);

    localparam int PB_W  = $clog2(PAGE_BYTES);
    localparam int SEG_W = PB_W + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, FILL, XFER_WR, XFER_RD, GAP
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  rem;
    logic [SEG_W-1:0]  seg;
    logic [PB_W-1:0]   idx;
    logic [GAP_W-1:0]  gap_cnt;
    logic [7:0]        page_buf [PAGE_BYTES];

    logic idx_last;
    logic rem_last;
    logic gap_end;

    // Bytes left in the page holding a, capped by the remaining length.
    function automatic logic [SEG_W-1:0] seg_len(
        input logic [ADDR_W-1:0] a,
        input logic [LEN_W-1:0]  r
    );
        logic [SEG_W-1:0] room;
        room = SEG_W'(PAGE_BYTES) - SEG_W'(a[PB_W-1:0]);
        if (r < LEN_W'(room)) seg_len = SEG_W'(r);
        else                  seg_len = room;
    endfunction

    assign idx_last    = (SEG_W'(idx) + SEG_W'(1)) == seg;
    assign rem_last    = rem == LEN_W'(1);
    assign gap_end     = gap_cnt == GAP_W'(GAP_CYCLES - 1);
    assign busy        = state != IDLE;
    assign ctl_address = addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ctl handshake outputs decode from state so that reset drops
    // ctl_parent_ready asynchronously.
    always_comb begin
        state_nxt        = state;
        cmd_ready        = 1'b0;
        wdata_ready      = 1'b0;
        ctl_parent_ready = 1'b0;
        ctl_wr_en        = 1'b0;
        ctl_last         = 1'b0;
        ctl_din          = 8'h00;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == '0) state_nxt = IDLE;
                    else if (cmd_wr)   state_nxt = FILL;
                    else               state_nxt = XFER_RD;
                end
            end
            FILL: begin
                wdata_ready = 1'b1;
                if (wdata_valid && idx_last) state_nxt = XFER_WR;
            end
            XFER_WR: begin
                ctl_parent_ready = 1'b1;
                ctl_wr_en        = 1'b1;
                ctl_din          = page_buf[idx];
                ctl_last         = idx_last;
                if (ctl_ready && idx_last) state_nxt = GAP;
            end
            XFER_RD: begin
                ctl_parent_ready = 1'b1;
                ctl_last         = rem_last;
                if (ctl_ready && rem_last) state_nxt = GAP;
            end
            GAP: begin
                if (gap_end) state_nxt = (rem != '0) ? FILL : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr        <= '0;
            rem         <= '0;
            seg         <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            done        <= 1'b0;
        end else begin
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            gap_cnt     <= '0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr <= cmd_addr;
                        rem  <= cmd_len;
                        seg  <= seg_len(cmd_addr, cmd_len);
                        idx  <= '0;
                        if (cmd_len == '0) done <= 1'b1;
                    end
                end
                FILL: begin
                    if (wdata_valid) idx <= idx_last ? '0 : idx + PB_W'(1);
                end
                XFER_WR: begin
                    if (ctl_ready) begin
                        if (idx_last) begin
                            idx  <= '0;
                            addr <= addr + ADDR_W'(seg);
                            rem  <= rem - LEN_W'(seg);
                        end else begin
                            idx <= idx + PB_W'(1);
                        end
                    end
                end
                XFER_RD: begin
                    if (ctl_ready) begin
                        rdata       <= ctl_dout;
                        rdata_valid <= 1'b1;
                        rdata_last  <= rem_last;
                        rem         <= rem - LEN_W'(1);
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        if (rem != '0) seg  <= seg_len(addr, rem);
                        else           done <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Page buffer is pure storage; contents before the first fill are unused.
    always_ff @(posedge clk) begin
        if (state == FILL && wdata_valid) page_buf[idx] <= wdata;
    end

endmodule
